bos_emulator: RTL and testbench

Synthesizable behavioural model of the SBIS BOS CCD signal processor's digital side, for bench and loopback testing of the functional-test path without silicon. It consumes the same signals the functional tester drives toward the chip: the 14-bit DAC word, clk/shp/shd, and clpob/pblk. It returns a pipelined 12-bit parallel output with its own data clock, exactly as the chip would on `q_fpga`/`dataclk_fpga`. All inputs come from registers in the `sys_clk` domain, so no synchronizers are needed.

---
 rtl/bos_emu_pkg.sv | 28 ++
 rtl/bos_emu_pipe.sv | 43 ++++
 rtl/bos_emulator.sv | 181 ++++++++++++++++++
 tb/tb_bos_emulator.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/bos_emu_pkg.sv
// Shared types, widths and helpers for the BOS CCD signal-processor emulator.
// Holds the phase FSM encoding and the 12-bit output saturator.
package bos_emu_pkg;

  localparam int DAC_W = 14;
  localparam int Q_W   = 12;
  localparam int OFS_W = 13;

  typedef enum logic [1:0] {
    WAIT_SHP = 2'd0,
    WAIT_SHD = 2'd1,
    CALC     = 2'd2
  } phase_e;

  function automatic logic [Q_W-1:0] sat12(
    input logic signed [13:0] v
  );
    logic [Q_W-1:0] r;
    if (v < 14'sd0)
      r = '0;
    else if (v > 14'sd4095)
      r = '1;
    else
      r = v[Q_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/bos_emu_pipe.sv
// LATENCY-deep 12-bit shift register advanced by shift_en, plus output reg.
// Ports: sys_clk, n_rst, shift_en, d (new pixel code), q (registered tail).
module bos_emu_pipe
  import bos_emu_pkg::*;
#(
  parameter int LATENCY = 9
) (
  input  logic           sys_clk,
  input  logic           n_rst,
  input  logic           shift_en,
  input  logic [Q_W-1:0] d,
  output logic [Q_W-1:0] q
);

  logic [Q_W-1:0] stage_q [LATENCY];
  logic [Q_W-1:0] stage_d [LATENCY];
  logic [Q_W-1:0] q_q;
  logic [Q_W-1:0] q_d;

  always_comb begin
    stage_d = stage_q;
    if (shift_en) begin
      stage_d[0] = d;
      for (int i = 1; i < LATENCY; i++)
        stage_d[i] = stage_q[i-1];
    end
    q_d = stage_q[LATENCY-1];
  end

  always_ff @(posedge sys_clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < LATENCY; i++)
        stage_q[i] <= '0;
      q_q <= '0;
    end else begin
      stage_q <= stage_d;
      q_q     <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/bos_emulator.sv
// Digital-side model of the BOS CCD processor: CDS/ADC capture, OB clamp,
// pipelined 12-bit output. Ports: tester strobes in; q/dataclk/debug out.
module bos_emulator
  import bos_emu_pkg::*;
#(
  parameter int LATENCY   = 9,
  parameter int OB_TARGET = 64,
  parameter int OB_SHIFT  = 3
) (
  input  logic             sys_clk,
  input  logic             n_rst,
  input  logic             ccd_mode,
  input  logic [DAC_W-1:0] dac_d,
  input  logic             clk_fpga,
  input  logic             shp_fpga,
  input  logic             shd_fpga,
  input  logic             clpob_fpga,
  input  logic             pblk_fpga,
  output logic             dataclk_fpga,
  output logic [Q_W-1:0]   q_fpga,
  output logic [15:0]      pix_cnt,
  output logic [7:0]       seq_err_cnt,
  output logic [OFS_W-1:0] ob_offset
);

  localparam logic signed [14:0] OB_T = 15'(OB_TARGET);

  phase_e state_q, state_d;

  logic             clk_dly_q, shp_dly_q, shd_dly_q;
  logic             dclk_q;
  logic [DAC_W-1:0] rst_lvl_q, rst_lvl_d;
  logic [DAC_W-1:0] vid_lvl_q, vid_lvl_d;
  logic [Q_W-1:0]   pend_q, pend_d;
  logic [15:0]      pix_q, pix_d;
  logic [7:0]       err_q, err_d;
  logic [OFS_W-1:0] ofs_q, ofs_d;

  logic shp_rise, shd_rise, clk_fall;
  logic err_inc;

  assign shp_rise = shp_fpga & ~shp_dly_q;
  assign shd_rise = shd_fpga & ~shd_dly_q;
  assign clk_fall = ~clk_fpga & clk_dly_q;

  logic [DAC_W-1:0]  cds_mag;
  logic              cds_neg;
  logic [Q_W-1:0]    cds12;
  logic signed [13:0] diff14;
  logic [Q_W-1:0]    code;
  logic signed [14:0] ob_err;
  logic signed [14:0] ob_step;
  logic signed [15:0] ob_sum;
  logic [OFS_W-1:0]  ofs_new;

  always_comb begin
    cds_neg = rst_lvl_q < vid_lvl_q;
    cds_mag = rst_lvl_q - vid_lvl_q;
    if (!ccd_mode)
      cds12 = vid_lvl_q[DAC_W-1:2];
    else if (cds_neg)
      cds12 = '0;
    else
      cds12 = 12'(cds_mag >> 2);

    diff14 = $signed({2'b00, cds12})
           - $signed({ofs_q[OFS_W-1], ofs_q});
    code = pblk_fpga ? '0 : sat12(diff14);

    ob_err = $signed({3'b000, cds12}) - OB_T
           - $signed({{2{ofs_q[OFS_W-1]}}, ofs_q});
    ob_step = ob_err >>> OB_SHIFT;
    ob_sum = $signed({ob_step[14], ob_step})
           + $signed({{3{ofs_q[OFS_W-1]}}, ofs_q});
    if (ob_sum > 16'sd4095)
      ofs_new = 13'h0FFF;
    else if (ob_sum < -16'sd4096)
      ofs_new = 13'h1000;
    else
      ofs_new = ob_sum[OFS_W-1:0];
  end

  always_ff @(posedge sys_clk or negedge n_rst) begin
    if (!n_rst)
      state_q <= WAIT_SHP;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_SHP: begin
        if (shp_rise)
          state_d = WAIT_SHD;
        else if (shd_rise && !ccd_mode)
          state_d = CALC;
      end
      WAIT_SHD: if (shd_rise) state_d = CALC;
      CALC:     state_d = WAIT_SHP;
      default:  state_d = WAIT_SHP;
    endcase
  end

  always_comb begin
    rst_lvl_d = rst_lvl_q;
    vid_lvl_d = vid_lvl_q;
    pend_d    = pend_q;
    pix_d     = pix_q;
    ofs_d     = ofs_q;
    err_inc   = 1'b0;
    unique case (state_q)
      WAIT_SHP: begin
        if (shp_rise) begin
          rst_lvl_d = dac_d;
          err_inc   = shd_rise;
        end else if (shd_rise) begin
          if (ccd_mode) err_inc = 1'b1;
          else          vid_lvl_d = dac_d;
        end
      end
      WAIT_SHD: begin
        if (shd_rise) begin
          vid_lvl_d = dac_d;
        end else if (shp_rise) begin
          err_inc   = 1'b1;
          rst_lvl_d = dac_d;
        end
      end
      CALC: begin
        pend_d = code;
        pix_d  = pix_q + 16'd1;
        if (clpob_fpga) ofs_d = ofs_new;
      end
      default: ;
    endcase
    err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end

  always_ff @(posedge sys_clk or negedge n_rst) begin
    if (!n_rst) begin
      clk_dly_q <= 1'b0;
      shp_dly_q <= 1'b0;
      shd_dly_q <= 1'b0;
      dclk_q    <= 1'b0;
      rst_lvl_q <= '0;
      vid_lvl_q <= '0;
      pend_q    <= '0;
      pix_q     <= '0;
      err_q     <= '0;
      ofs_q     <= '0;
    end else begin
      clk_dly_q <= clk_fpga;
      shp_dly_q <= shp_fpga;
      shd_dly_q <= shd_fpga;
      dclk_q    <= clk_fpga;
      rst_lvl_q <= rst_lvl_d;
      vid_lvl_q <= vid_lvl_d;
      pend_q    <= pend_d;
      pix_q     <= pix_d;
      err_q     <= err_d;
      ofs_q     <= ofs_d;
    end
  end

  bos_emu_pipe #(
    .LATENCY (LATENCY)
  ) u_pipe (
    .sys_clk  (sys_clk),
    .n_rst    (n_rst),
    .shift_en (clk_fall),
    .d        (pend_q),
    .q        (q_fpga)
  );

  assign dataclk_fpga = dclk_q;
  assign pix_cnt      = pix_q;
  assign seq_err_cnt  = err_q;
  assign ob_offset    = ofs_q;

endmodule

// File: tb/tb_bos_emulator.sv
// Self-checking bench for bos_emulator (LATENCY=3): directed + random pixels
// compared against a pixel-level reference model.
module tb_bos_emulator;

  localparam int LAT = 3;

  logic        sys_clk = 1'b0;
  logic        n_rst;
  logic        ccd_mode;
  logic [13:0] dac_d;
  logic        clk_fpga, shp_fpga, shd_fpga;
  logic        clpob_fpga, pblk_fpga;
  logic        dataclk_fpga;
  logic [11:0] q_fpga;
  logic [15:0] pix_cnt;
  logic [7:0]  seq_err_cnt;
  logic [12:0] ob_offset;

  always #5 sys_clk = ~sys_clk;

  bos_emulator #(
    .LATENCY   (LAT),
    .OB_TARGET (64),
    .OB_SHIFT  (3)
  ) dut (
    .sys_clk      (sys_clk),
    .n_rst        (n_rst),
    .ccd_mode     (ccd_mode),
    .dac_d        (dac_d),
    .clk_fpga     (clk_fpga),
    .shp_fpga     (shp_fpga),
    .shd_fpga     (shd_fpga),
    .clpob_fpga   (clpob_fpga),
    .pblk_fpga    (pblk_fpga),
    .dataclk_fpga (dataclk_fpga),
    .q_fpga       (q_fpga),
    .pix_cnt      (pix_cnt),
    .seq_err_cnt  (seq_err_cnt),
    .ob_offset    (ob_offset)
  );

  int checks = 0;
  int errors = 0;

  int m_ofs, m_pend, m_pix, m_err;
  int fall_hist[$];

  task automatic chk(input string tag, input integer obs,
                     input integer exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  function automatic int exp_q();
    return fall_hist[fall_hist.size() - LAT];
  endfunction

  task automatic model_reset();
    m_ofs = 0; m_pend = 0; m_pix = 0; m_err = 0;
    fall_hist.delete();
    for (int i = 0; i < LAT; i++) fall_hist.push_back(0);
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_q"},   q_fpga, exp_q());
    chk({tag, "_pix"}, pix_cnt, m_pix);
    chk({tag, "_err"}, seq_err_cnt, m_err);
    chk({tag, "_ofs"}, $signed(ob_offset), m_ofs);
  endtask

  // kind: 0 shp+shd, 1 shd only, 2 shp twice then shd, 3 shp&shd together
  task automatic pixel(input bit mode, input int rl, input int vl,
                       input bit ob, input bit pb, input int kind);
    bit valid;
    int cds12, code, ns;
    ccd_mode   = mode;
    clpob_fpga = ob;
    pblk_fpga  = pb;
    for (int s = 0; s < 12; s++) begin
      clk_fpga = (s < 6);
      shp_fpga = (kind != 1 && s == 0) || (kind == 2 && s == 2);
      shd_fpga = (s == 4) || (kind == 3 && s == 0);
      dac_d    = 14'($urandom);
      if (s == 0 && kind == 2) dac_d = 14'($urandom);
      else if (s == 0)         dac_d = 14'(rl);
      if (s == 2 && kind == 2) dac_d = 14'(rl);
      if (s == 4)              dac_d = 14'(vl);
      tick();
      if (s == 3) chk("dataclk_hi", dataclk_fpga, 1);
      if (s == 9) chk("dataclk_lo", dataclk_fpga, 0);
    end
    shd_fpga = 1'b0;
    shp_fpga = 1'b0;
    valid = 1'b1;
    if (mode && kind == 1) begin
      valid = 1'b0;
      if (m_err < 255) m_err++;
    end
    if ((kind == 2 || kind == 3) && m_err < 255) m_err++;
    if (valid) begin
      if (mode) cds12 = (rl > vl) ? (rl - vl) / 4 : 0;
      else      cds12 = vl / 4;
      code = cds12 - m_ofs;
      if (code < 0)    code = 0;
      if (code > 4095) code = 4095;
      if (pb) code = 0;
      if (ob) begin
        ns = m_ofs + ((cds12 - 64 - m_ofs) >>> 3);
        if (ns > 4095)  ns = 4095;
        if (ns < -4096) ns = -4096;
        m_ofs = ns;
      end
      m_pend = code;
      m_pix  = (m_pix + 1) % 65536;
    end
    fall_hist.push_back(m_pend);
    check_state("pix");
  endtask

  task automatic rand_pixel();
    int r;
    int kind;
    r = $urandom_range(0, 9);
    kind = (r < 7) ? 0 : r - 6;
    pixel(1'($urandom_range(0, 1)), $urandom_range(0, 16383),
          $urandom_range(0, 16383), $urandom_range(0, 3) == 0,
          $urandom_range(0, 7) == 0, kind);
  endtask

  initial begin
    n_rst = 1'b0;
    ccd_mode = 1'b1; dac_d = '0;
    clk_fpga = 1'b0; shp_fpga = 1'b0; shd_fpga = 1'b0;
    clpob_fpga = 1'b0; pblk_fpga = 1'b0;
    model_reset();
    repeat (3) tick();
    check_state("reset");
    chk("reset_dclk", dataclk_fpga, 0);
    n_rst = 1'b1;
    tick();

    pixel(1, 8000, 4000, 0, 0, 0);
    chk("plan_pix1", pix_cnt, 1);
    pixel(0, 0, 0, 0, 0, 0);
    pixel(0, 0, 0, 0, 0, 0);
    chk("plan_q1000", q_fpga, 1000);
    pixel(0, 0, 10000, 0, 0, 0);
    pixel(0, 0, 0, 0, 0, 0);
    pixel(0, 0, 0, 0, 0, 0);
    chk("plan_q2500", q_fpga, 2500);
    pixel(0, 0, 0, 0, 0, 0);
    chk("plan_vid0", q_fpga, 0);
    pixel(1, 800, 0, 1, 0, 0);
    chk("plan_ofs17", $signed(ob_offset), 17);
    pixel(1, 800, 0, 1, 0, 0);
    chk("plan_ofs31", $signed(ob_offset), 31);
    pixel(1, 40, 0, 0, 0, 0);
    pixel(0, 0, 0, 0, 0, 0);
    pixel(0, 0, 0, 0, 0, 0);
    chk("plan_sat0", q_fpga, 0);
    pixel(1, 0, 5000, 0, 0, 1);
    chk("plan_err1", seq_err_cnt, 1);
    chk("plan_pix12", pix_cnt, 12);
    pixel(1, 8000, 0, 0, 0, 2);
    chk("plan_err2", seq_err_cnt, 2);
    pixel(1, 4000, 0, 0, 1, 0);
    chk("plan_pix14", pix_cnt, 14);
    pixel(0, 0, 0, 0, 0, 0);
    chk("plan_q1969", q_fpga, 1969);
    pixel(0, 0, 0, 0, 0, 0);
    chk("plan_pblk0", q_fpga, 0);

    for (int i = 0; i < 150; i++) rand_pixel();

    repeat (20) tick();
    check_state("hold");

    ccd_mode = 1'b1; clk_fpga = 1'b1;
    shp_fpga = 1'b1; dac_d = 14'd9000;
    tick();
    shp_fpga = 1'b0;
    tick();
    #2;
    n_rst = 1'b0;
    clk_fpga = 1'b0;
    #1;
    model_reset();
    check_state("midrst");
    chk("midrst_dclk", dataclk_fpga, 0);
    tick();
    n_rst = 1'b1;
    tick();

    for (int i = 0; i < LAT - 1; i++) begin
      pixel(1, 12000, 100, 0, 0, 0);
      chk("post_rst_q0", q_fpga, 0);
      if (i == 0) chk("post_rst_pix1", pix_cnt, 1);
    end

    for (int i = 0; i < 50; i++) rand_pixel();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
